// File: rtl/mux5_rr_sched_pkg.sv
// Shared types, constants and the round-robin pick helper for the 5-way scheduler.
package mux5_rr_sched_pkg;

    localparam int N_SRC = 5;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set request scanning upward from last+1 with wrap. The last
    // holder itself is visited last, so it only wins when it is alone.
    function automatic rr_pick_t rr_next(input logic [SEL_W-1:0] last,
                                         input logic [N_SRC-1:0] req);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = (int'(last) + k) % N_SRC;
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = SEL_W'(cand);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux5_rr_sched_if.sv
// Requester-side bus of the scheduler: requests and data in, grant/select/data out.
interface mux5_rr_sched_if;
    import mux5_rr_sched_pkg::*;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] a;
    logic [N_SRC-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             y;

    modport master (output req, output a, input gnt, input sel, input busy, input y);
    modport slave  (input req, input a, output gnt, output sel, output busy, output y);

endinterface

// File: rtl/mux5_rr_sched_mux5_1.sv
// Combinational 5:1 single-bit mux; out-of-range selects read as 0.
module mux5_1
    import mux5_rr_sched_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [N_SRC-1:0] a,
    output logic             y
);

    // Plain decode; 5..7 are unreachable but still resolve to a quiet 0.
    always_comb begin
        case (sel)
            3'd0:    y = a[0];
            3'd1:    y = a[1];
            3'd2:    y = a[2];
            3'd3:    y = a[3];
            3'd4:    y = a[4];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux5_rr_sched.sv
// Round-robin arbiter that drives the shared 5:1 mux select and registers its output.
module mux5_rr_sched
    import mux5_rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mux5_rr_sched_if.slave   bus
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             y_q;

    logic             busy;
    logic [N_SRC-1:0] gnt;
    logic             mux_bit;
    rr_pick_t         pick;
    logic             holder_req;
    logic             release_now;

    mux5_1 u_mux (
        .sel (sel_q),
        .a   (bus.a),
        .y   (mux_bit)
    );

    // State register: arbiter state plus the output bit, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= 3'd4;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            y_q     <= busy ? mux_bit : 1'b0;
        end
    end

    // Next state: grant from idle, or on release hand off directly without a bubble.
    always_comb begin
        pick        = rr_next(last_q, bus.req);
        holder_req  = |(bus.req & gnt);
        release_now = !holder_req || (cnt_q == HOLD_LAST);
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                    sel_d   = pick.idx;
                    last_d  = pick.idx;
                end
            end
            GRANT: begin
                if (release_now) begin
                    cnt_d = '0;
                    if (pick.found) begin
                        sel_d  = pick.idx;
                        last_d = pick.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase
    end

    // Outputs: grant is the one-hot of sel while granting; sel itself is held in idle.
    always_comb begin
        busy = (state_q == GRANT);
        gnt  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            gnt[i] = busy && (sel_q == SEL_W'(i));
        end
    end

    assign bus.gnt  = gnt;
    assign bus.busy = busy;
    assign bus.sel  = sel_q;
    assign bus.y    = y_q;

endmodule

// File: tb/tb_mux5_rr_sched.sv
// Directed bench for mux5_rr_sched with a cycle-level reference model and literal spot checks.
module tb_mux5_rr_sched;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mux5_rr_sched_if bus ();

    mux5_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: owner = granted requester or -1, tenure counted in cycles.
    int   m_own = -1;
    int   m_cnt = 0;
    int   m_last = 4;
    int   m_sel = 0;
    int   m_pick;
    logic m_y = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_cnt = 0; m_last = 4; m_sel = 0; m_y = 1'b0;
        end else begin
            m_y = (m_own >= 0) ? bus.a[m_sel] : 1'b0;
            if (m_own < 0 || !bus.req[m_own] || m_cnt == MAX_HOLD - 1) begin
                m_pick = -1;
                for (int k = 1; k <= 5; k++)
                    if (m_pick < 0 && bus.req[(m_last + k) % 5]) m_pick = (m_last + k) % 5;
                if (m_pick >= 0) begin
                    m_own = m_pick; m_cnt = 0; m_last = m_pick; m_sel = m_pick;
                end else begin
                    m_own = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_gnt",  32'(bus.gnt),  (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("model_sel",  32'(bus.sel),  32'(m_sel));
        chk("model_busy", 32'(bus.busy), 32'(m_own >= 0));
        chk("model_y",    32'(bus.y),    32'(m_y));
        chk("sel_range",  32'(bus.sel <= 3'd4), 32'd1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] av;
        bus.req = '0;
        bus.a   = '0;

        // 1: reset then idle
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #4;
            chk("idle_gnt", 32'(bus.gnt), 32'h0);
            chk("idle_sel", 32'(bus.sel), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_y", 32'(bus.y), 32'd0);
        end

        // 2: sole requester 2, forced re-grant is seamless
        bus.req = 5'b00100; bus.a = 5'b00100;
        @(posedge clk); #4;
        chk("t2_gnt", 32'(bus.gnt), 32'h04);
        chk("t2_sel", 32'(bus.sel), 32'd2);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        chk("t2_y_lag", 32'(bus.y), 32'd0);
        @(posedge clk); #4;
        chk("t2_y", 32'(bus.y), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #4;
            chk("t2_hold", 32'(bus.gnt), 32'h04);
        end

        // 3: all requesting, 4-cycle tenures rotating 0..4
        do_reset();
        bus.req = 5'b11111; bus.a = '0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #4;
            chk("t3_rot", 32'(bus.gnt), 32'd1 << ((i / 4) % 5));
        end

        // 4: holder 1 drops, round-robin skips past 0 to 3
        do_reset();
        bus.req = 5'b00010;
        @(posedge clk); #4;
        chk("t4_g1", 32'(bus.gnt), 32'h02);
        @(posedge clk); #2;
        bus.req = 5'b01001; bus.a = 5'b01000;
        @(posedge clk); #4;
        chk("t4_g3", 32'(bus.gnt), 32'h08);
        chk("t4_sel3", 32'(bus.sel), 32'd3);
        @(posedge clk); #4;
        chk("t4_y", 32'(bus.y), 32'd1);

        // 5: asynchronous reset mid-grant, then requester 0 first
        #3 rst_n = 1'b0;
        #1;
        chk("t5_gnt", 32'(bus.gnt), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_y", 32'(bus.y), 32'd0);
        chk("t5_sel", 32'(bus.sel), 32'd0);
        bus.req = 5'b10001;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #4;
        chk("t5_first", 32'(bus.gnt), 32'h01);

        // 6: data path follows the grant with one cycle of lag
        do_reset();
        av = 5'b01010;
        bus.req = 5'b11111; bus.a = av;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #4;
            chk("t6_y", 32'(bus.y), (i == 0) ? 32'd0 : 32'(av[((i - 1) / 4) % 5]));
        end

        bus.req = '0;
        repeat (3) @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
